// File: rtl/alu_pipe_if.sv
// Request/result bundle for alu_pipe: valid/ready request side, valid/ready result side, busy.
// No storage; pure signal grouping.
// Backpressure travels on in_ready/out_ready.
interface alu_pipe_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [3:0]       flags_in;
    logic [3:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_z;
    logic [3:0]       flags_out;
    logic             busy;

    modport master (
        output in_valid, data_a, data_b, flags_in, operation, out_ready,
        input  in_ready, out_valid, data_z, flags_out, busy
    );

    modport slave (
        input  in_valid, data_a, data_b, flags_in, operation, out_ready,
        output in_ready, out_valid, data_z, flags_out, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU with {V,N,Z,C} flags and an iterative shift-and-add multiplier.
// Latency: 1 cycle for ALU ops, WIDTH+1 cycles for MUL.
// Backpressure: a held result (out_valid & !out_ready) or a running multiply drops in_ready.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input logic       clock,
    input logic       reset_n,
    alu_pipe_if.slave io
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ASR = 4'd10, OP_CMP = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [3:0]       flags;
    } res_t;

    state_t             state, state_nxt;
    logic               accept, mul_last, out_valid, in_ready;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH:0]     add_r, sub_r;
    logic [WIDTH-1:0]   alu_data, alu_fdata;
    logic               alu_c, alu_v, add_v, sub_v;
    res_t               alu_res, mul_res, out_r;

    assign accept   = io.in_valid & in_ready;
    assign mul_last = (state == MUL) && (cnt == LAST);

    // FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && io.operation == OP_MUL) state_nxt = MUL;
            MUL:  if (mul_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs; in_ready is held low while reset is asserted
    always_comb begin
        in_ready = reset_n && (state == IDLE) && (!out_valid || io.out_ready);
        io.busy  = (state == MUL);
    end

    always_comb begin
        add_r = {1'b0, io.data_a} + {1'b0, io.data_b}
              + (WIDTH+1)'((io.operation == OP_ADC) & io.flags_in[0]);
        sub_r = {1'b0, io.data_a} - {1'b0, io.data_b}
              - (WIDTH+1)'((io.operation == OP_SBB) & io.flags_in[0]);
        add_v = (io.data_a[WIDTH-1] == io.data_b[WIDTH-1]) && (add_r[WIDTH-1] != io.data_a[WIDTH-1]);
        sub_v = (io.data_a[WIDTH-1] != io.data_b[WIDTH-1]) && (sub_r[WIDTH-1] != io.data_a[WIDTH-1]);
    end

    // alu_fdata is what N/Z look at; it differs from the result only for CMP
    always_comb begin
        alu_data  = io.data_a;
        alu_fdata = io.data_a;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        case (io.operation)
            OP_ADD, OP_ADC: begin
                alu_data = add_r[WIDTH-1:0]; alu_fdata = alu_data;
                alu_c = add_r[WIDTH]; alu_v = add_v;
            end
            OP_SUB, OP_SBB: begin
                alu_data = sub_r[WIDTH-1:0]; alu_fdata = alu_data;
                alu_c = sub_r[WIDTH]; alu_v = sub_v;
            end
            OP_CMP: begin
                alu_fdata = sub_r[WIDTH-1:0];
                alu_c = sub_r[WIDTH]; alu_v = sub_v;
            end
            OP_AND: begin alu_data = io.data_a & io.data_b; alu_fdata = alu_data; end
            OP_OR:  begin alu_data = io.data_a | io.data_b; alu_fdata = alu_data; end
            OP_XOR: begin alu_data = io.data_a ^ io.data_b; alu_fdata = alu_data; end
            OP_NOT: begin alu_data = ~io.data_a;            alu_fdata = alu_data; end
            OP_SHL: begin
                alu_data = {io.data_a[WIDTH-2:0], 1'b0}; alu_fdata = alu_data;
                alu_c = io.data_a[WIDTH-1];
            end
            OP_SHR: begin
                alu_data = {1'b0, io.data_a[WIDTH-1:1]}; alu_fdata = alu_data;
                alu_c = io.data_a[0];
            end
            OP_ASR: begin
                alu_data = {io.data_a[WIDTH-1], io.data_a[WIDTH-1:1]}; alu_fdata = alu_data;
                alu_c = io.data_a[0];
            end
            default: ;
        endcase
        alu_res.data  = alu_data;
        alu_res.flags = {alu_v, alu_fdata[WIDTH-1], (alu_fdata == '0), alu_c};
        if (io.operation > OP_MUL) alu_res.flags = io.flags_in;
    end

    // One partial product per cycle; the final sum feeds the output register directly
    always_comb begin
        acc_nxt       = acc + (mplier[0] ? mcand : '0);
        mul_res.data  = acc_nxt[WIDTH-1:0];
        mul_res.flags = {1'b0, acc_nxt[WIDTH-1], (acc_nxt[WIDTH-1:0] == '0),
                         (acc_nxt[2*WIDTH-1:WIDTH] != '0)};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && io.operation == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, io.data_a};
            mplier <= io.data_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
            cnt    <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_r     <= '0;
            out_valid <= 1'b0;
        end else if (accept && io.operation != OP_MUL) begin
            out_r     <= alu_res;
            out_valid <= 1'b1;
        end else if (mul_last) begin
            out_r     <= mul_res;
            out_valid <= 1'b1;
        end else if (io.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid;
    assign io.data_z    = out_r.data;
    assign io.flags_out = out_r.flags;
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal 4..32).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block accepts a request this cycle.
REQ-006 Port: data_a  input  WIDTH  operand A.
REQ-007 Port: data_b  input  WIDTH  operand B.
REQ-008 Port: flags_in  input  4  incoming flags {V,N,Z,C} (bit3..bit0); only C is consumed.
REQ-009 Port: operation  input  4  opcode per REQ-015.
REQ-010 Port: out_valid  output  1  data_z/flags_out hold a result.
REQ-011 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port: data_z  output  WIDTH  result.
REQ-013 Port: flags_out  output  4  result flags {V,N,Z,C}.
REQ-014 Port: busy  output  1  multiply in progress.

Function
REQ-015 The block SHALL support these opcodes: 0 ADD A+B; 1 ADC A+B+Cin; 2 SUB A-B; 3 SBB A-B-Cin; 4 AND; 5 OR; 6 XOR; 7 NOT A; 8 SHL A<<1; 9 SHR logical A>>1; 10 ASR A>>>1; 11 CMP (flags of A-B, data_z=A); 12 MUL (low WIDTH bits of A*B, unsigned); 13-15 reserved.
REQ-016 A request SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; operands and opcode SHALL be captured at acceptance.
REQ-017 in_ready SHALL be 1 when state is IDLE and (out_valid=0 or out_ready=1), else 0.
REQ-018 The state machine SHALL have states IDLE and MUL; IDLE->MUL on accepting opcode 12; MUL->IDLE after WIDTH iteration cycles; all other opcodes stay in IDLE.
REQ-019 Non-MUL results SHALL appear with out_valid=1 on the cycle after acceptance (latency 1).
REQ-020 MUL SHALL be computed by shift-and-add, one partial product per cycle, with out_valid=1 exactly WIDTH+1 cycles after acceptance; busy=1 while in MUL.
REQ-021 out_valid SHALL clear on a cycle with out_ready=1 unless a new result is loaded that same cycle; data_z and flags_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Flag Z SHALL be 1 iff the WIDTH-bit result is zero; N SHALL equal result bit WIDTH-1.
REQ-023 For ADD/ADC, C SHALL be the carry out of bit WIDTH-1; for SUB/SBB/CMP, C SHALL be the borrow (1 when unsigned A < B + borrow-in).
REQ-024 V SHALL be two's-complement overflow for ADD/ADC/SUB/SBB/CMP; V SHALL be 0 for all other opcodes.
REQ-025 For SHL/SHR/ASR, C SHALL be the bit shifted out; for AND/OR/XOR/NOT, C SHALL be 0.
REQ-026 For MUL, C SHALL be 1 iff the upper WIDTH bits of the full 2*WIDTH product are non-zero.
REQ-027 Reserved opcodes SHALL return data_z=A and flags_out=flags_in with latency 1.
REQ-028 Requests presented while in_ready=0 SHALL be ignored and not queued.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, out_valid=0, busy=0, data_z=0, flags_out=0, aborting any multiply.
REQ-030 in_ready SHALL be 1 on the first clock edge after reset_n deasserts.

Verification
REQ-031 WIDTH=8, ADD A=0xFF B=0x01 -> next cycle data_z=0x00, flags_out C=1 Z=1 N=0 V=0.
REQ-032 WIDTH=8, SUB A=0x80 B=0x01 -> data_z=0x7F, V=1 N=0 C=0 Z=0.
REQ-033 WIDTH=8, MUL A=0x10 B=0x10 -> in_ready=0 and busy=1 for 8 cycles, out_valid exactly 9 cycles after accept, data_z=0x00, C=1 Z=1.
REQ-034 ADD result held with out_ready=0 for 3 cycles -> data_z/flags_out unchanged, in_ready=0; new request accepted on the cycle out_ready=1, next result follows one cycle later.
REQ-035 reset_n pulsed low during MUL cycle 4 -> all outputs 0 immediately, no result emitted, in_ready=1 after release.
REQ-036 WIDTH=16, ADC A=0xFFFF B=0x0000 flags_in C=1 -> data_z=0x0000, C=1 Z=1 V=0.
